// File: rtl/tdm_demux4_pkg.sv
// Shared slot definitions for the 4-channel TDM demultiplexer.
package tdm_demux4_pkg;

    localparam int SLOTS = 4;

    typedef logic [1:0] slot_t;

    function automatic logic [SLOTS-1:0] slot_onehot(input slot_t s);
        logic [SLOTS-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Rolling 2-bit TDM slot index: advances on each valid sample, realigns on sync.
// Registered output, no backpressure.
module tdm_slot_ctr
    import tdm_demux4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  adv,
    input  logic  sync,
    output slot_t slot
);

    slot_t slot_q, slot_d;

    // A sync sample occupies slot 0 itself, so the next one lands in slot 1.
    always_comb begin
        slot_d = slot_q;
        if (sync) begin
            slot_d = adv ? slot_t'(1) : slot_t'(0);
        end else if (adv) begin
            slot_d = slot_q + slot_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demux: routes a serial sample stream into four channels and assembles full frames.
// One register stage of latency on every output; no backpressure, one sample per cycle sustained.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         din,
    input  logic                 din_valid,
    input  logic                 sync,
    output logic [SLOTS*W-1:0]   ch_data,
    output logic [SLOTS-1:0]     ch_strobe,
    output logic [SLOTS*W-1:0]   frame,
    output logic                 frame_valid,
    output logic [1:0]           slot,
    output logic                 sync_err
);

    slot_t               slot_cur;
    slot_t               cap_slot;
    logic                discard;

    logic [SLOTS*W-1:0]  ch_data_q,     ch_data_d;
    logic [SLOTS*W-1:0]  asm_q,         asm_d;
    logic [SLOTS*W-1:0]  frame_q,       frame_d;
    logic [SLOTS-1:0]    ch_strobe_q,   ch_strobe_d;
    logic                frame_valid_q, frame_valid_d;
    logic                sync_err_q,    sync_err_d;
    logic                trk_q,         trk_d;

    tdm_slot_ctr u_slot_ctr (
        .clk  (clk),
        .rst  (rst),
        .adv  (din_valid),
        .sync (sync),
        .slot (slot_cur)
    );

    // trk_q: a slot-0 capture has been seen and nothing since has broken the frame.
    always_comb begin
        cap_slot      = sync ? slot_t'(0) : slot_cur;
        discard       = sync && (slot_cur != slot_t'(0));
        ch_data_d     = ch_data_q;
        asm_d         = asm_q;
        frame_d       = frame_q;
        ch_strobe_d   = '0;
        frame_valid_d = 1'b0;
        sync_err_d    = discard;
        trk_d         = trk_q;
        if (din_valid) begin
            ch_strobe_d                     = slot_onehot(cap_slot);
            ch_data_d[int'(cap_slot)*W +: W] = din;
            asm_d[int'(cap_slot)*W +: W]     = din;
            if (cap_slot == slot_t'(0)) begin
                trk_d = 1'b1;
            end else if (cap_slot == slot_t'(3)) begin
                if (trk_q) frame_d = asm_d;
                frame_valid_d = trk_q;
                trk_d         = 1'b0;
            end
        end else if (discard) begin
            trk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_data_q     <= '0;
            asm_q         <= '0;
            frame_q       <= '0;
            ch_strobe_q   <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            trk_q         <= 1'b0;
        end else begin
            ch_data_q     <= ch_data_d;
            asm_q         <= asm_d;
            frame_q       <= frame_d;
            ch_strobe_q   <= ch_strobe_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            trk_q         <= trk_d;
        end
    end

    assign ch_data     = ch_data_q;
    assign ch_strobe   = ch_strobe_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_cur;
    assign sync_err    = sync_err_q;

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, default 1, width of each sample in bits.
REQ-002 Port: clk  input  1  the single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  W  serial time-multiplexed sample.
REQ-005 Port: din_valid  input  1  din holds a sample this cycle.
REQ-006 Port: sync  input  1  frame-alignment marker; a sample with sync is slot 0.
REQ-007 Port: ch_data  output  4*W  latest sample per channel; channel k occupies bits [k*W +: W].
REQ-008 Port: ch_strobe  output  4  one-hot pulse; bit k high for one cycle when channel k updates.
REQ-009 Port: frame  output  4*W  last complete frame; same channel layout as ch_data.
REQ-010 Port: frame_valid  output  1  one-cycle pulse; frame just updated.
REQ-011 Port: slot  output  2  slot index the next valid sample will occupy.
REQ-012 Port: sync_err  output  1  one-cycle pulse; sync arrived while slot != 0.

Function
REQ-013 The block is the 1-to-4 counterpart of the team's 4:1 mux: it routes one input stream to four channels by a rolling 2-bit slot index.
REQ-014 On a clk edge with din_valid=1 and sync=0, din is written to ch_data channel slot, ch_strobe[slot] pulses, and slot increments mod 4 (3 -> 0).
REQ-015 On a clk edge with din_valid=1 and sync=1, din is written to channel 0, ch_strobe[0] pulses, and slot becomes 1.
REQ-016 On a clk edge with din_valid=0 and sync=1, slot becomes 0 and no channel is written.
REQ-017 With din_valid=0 and sync=0, all state holds and ch_strobe, frame_valid and sync_err are 0.
REQ-018 Latency: ch_data and ch_strobe reflect a sample in the cycle after the edge that captured it (one register stage).
REQ-019 Each capture also writes an internal assembly buffer; a channel-3 capture with no discarded slots since the last slot-0 capture copies the full buffer, including that channel-3 sample, to frame and pulses frame_valid in the same cycle as ch_strobe[3].
REQ-020 sync while slot != 0 marks the partial frame discarded, so no frame_valid is produced for it; sync_err pulses in the cycle after that edge.
REQ-021 Frames are tracked from the first slot-0 capture; a channel-3 capture before any slot-0 capture since reset produces no frame_valid.
REQ-022 frame changes only on frame_valid; ch_data channels change only on their own strobe.
REQ-023 Back-to-back valid samples every cycle are sustained with no stall; there is no backpressure.

Reset
REQ-024 While rst=1: slot=0, ch_data=0, frame=0, ch_strobe=0, frame_valid=0, sync_err=0, and the frame-tracking state is cleared.
REQ-025 When rst is asserted mid-frame, the partial frame is discarded and no frame_valid follows its deassertion.
REQ-026 The first valid sample after rst deassertion occupies slot 0.

Structure
REQ-027 A shared package holds SLOTS=4, the 2-bit slot typedef and the slot-to-one-hot decode function.
REQ-028 The slot counter is a sub-module named tdm_slot_ctr (inputs: clk, rst, adv, sync; output: slot).

Verification
REQ-029 Reset then din_valid=1 for 4 cycles with din=0,1,0,1 (W=1): ch_strobe sequence 0001,0010,0100,1000; frame=4'b1010 with one frame_valid pulse; slot back to 0.
REQ-030 Continuous stream of 8 samples, din=1,0,1,0,0,1,1,0: exactly two frame_valid pulses, frames 4'b0101 then 4'b0110.
REQ-031 Two samples, then sync with din_valid=1 and din=1: sync_err pulses once, ch_data channel 0 = 1, slot=1, no frame_valid until 3 more samples arrive.
REQ-032 sync with din_valid=0 at slot=2: slot goes to 0, no strobe, sync_err pulses, ch_data unchanged.
REQ-033 rst asserted asynchronously between edges after 3 samples: all outputs go to 0 immediately; the next 4 samples yield one frame_valid.
REQ-034 din_valid gapped (1,0,0,1,1,0,1): slot advances only on valid cycles, and one frame_valid occurs on the fourth valid sample.
